mdll_jm_counter: RTL and testbench

MDLL_JM_COUNTER -- requirements
Module: mdll_jm_counter

---
 rtl/mdll_jm_pkg.sv | 31 +++
 rtl/mdll_jm_satcnt.sv | 59 +++++
 rtl/mdll_jm_counter.sv | 137 +++++++++++++
 tb/tb_mdll_jm_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mdll_jm_pkg.sv
// ============================================================================
// Module : mdll_jm_pkg
// Brief  : Shared types and constants for the MDLL jitter-measurement counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mdll_jm_pkg;

  localparam int              JM_W   = 20;
  localparam int              NCYC_W = 6;
  localparam int              TICK_W = NCYC_W + 1;
  localparam logic [JM_W-1:0] JM_MAX = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } jm_state_e;

  // A programmed length of 0 selects the longest window, 64 reference periods.
  function automatic logic [TICK_W-1:0] ncyc_decode(input logic [NCYC_W-1:0] n);
    logic [TICK_W-1:0] v;
    v = (n == '0) ? TICK_W'(64) : {1'b0, n};
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdll_jm_satcnt.sv
// ============================================================================
// Module : mdll_jm_satcnt
// Brief  : Saturating up-counter; o_count/o_sat report the value including
//          this cycle's clear/increment so a window can close on its last cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdll_jm_satcnt
  import mdll_jm_pkg::*;
#(
  parameter int             W   = JM_W,
  parameter logic [W-1:0]   MAX = JM_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_sat
);

  logic [W-1:0] r_count;
  logic         r_sat;
  logic [W-1:0] w_count_nxt;
  logic         w_sat_nxt;

  always_comb begin
    w_count_nxt = r_count;
    w_sat_nxt   = r_sat;
    if (i_clear) begin
      w_count_nxt = '0;
      w_sat_nxt   = 1'b0;
    end else if (i_inc) begin
      // An increment attempted at the ceiling is what marks saturation.
      if (r_count == MAX) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign o_count = w_count_nxt;
  assign o_sat   = w_sat_nxt;

endmodule

`default_nettype wire

// File: rtl/mdll_jm_counter.sv
// ============================================================================
// Module : mdll_jm_counter
// Brief  : Counts phase-detector ones over N reference periods for jitter
//          estimation; results held in output flops until the next window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdll_jm_counter
  import mdll_jm_pkg::*;
#(
  parameter logic [JM_W-1:0] SAT_MAX = JM_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_jm,
  input  logic [NCYC_W-1:0] ncycle_jm,
  input  logic              fref_tick,
  input  logic              pd_bit,
  output logic [JM_W-1:0]   jm_out,
  output logic [JM_W-1:0]   jm_nsamp,
  output logic              jm_busy,
  output logic              jm_done,
  output logic              jm_sat
);

  jm_state_e         r_state;
  jm_state_e         w_state_nxt;
  logic              r_en_q;
  logic              r_en_armed;
  logic [TICK_W-1:0] r_ncyc;
  logic [TICK_W-1:0] r_tick;
  logic [JM_W-1:0]   r_jm_out;
  logic [JM_W-1:0]   r_jm_nsamp;
  logic              r_jm_sat;
  logic              r_busy;
  logic              r_done;

  logic              w_en_rise;
  logic [TICK_W-1:0] w_tick_inc;
  logic              w_start;
  logic              w_run;
  logic              w_last;
  logic [JM_W-1:0]   w_ones_cnt;
  logic [JM_W-1:0]   w_samp_cnt;
  logic              w_ones_sat;
  logic              w_samp_sat;

  // r_en_armed blocks a false edge when en_jm is already high as reset lifts.
  assign w_en_rise  = en_jm && !r_en_q && r_en_armed;
  assign w_tick_inc = r_tick + TICK_W'(1);
  assign w_start    = (r_state == ARM) && fref_tick;
  assign w_run      = (r_state == RUN);
  assign w_last     = w_run && en_jm && fref_tick && (w_tick_inc == r_ncyc);

  mdll_jm_satcnt #(
    .W   (JM_W),
    .MAX (SAT_MAX)
  ) u_ones_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_start),
    .i_inc   (w_run && pd_bit),
    .o_count (w_ones_cnt),
    .o_sat   (w_ones_sat)
  );

  mdll_jm_satcnt #(
    .W   (JM_W),
    .MAX (SAT_MAX)
  ) u_samp_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_start),
    .i_inc   (w_run),
    .o_count (w_samp_cnt),
    .o_sat   (w_samp_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_en_rise) w_state_nxt = ARM;
      ARM: begin
        if (!en_jm)         w_state_nxt = IDLE;
        else if (fref_tick) w_state_nxt = RUN;
      end
      RUN: begin
        if (!en_jm)      w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE: if (!en_jm) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en_q     <= 1'b0;
      r_en_armed <= 1'b0;
      r_ncyc     <= '0;
      r_tick     <= '0;
      r_jm_out   <= '0;
      r_jm_nsamp <= '0;
      r_jm_sat   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_q  <= en_jm;
      if (!en_jm) r_en_armed <= 1'b1;
      if ((r_state == IDLE) && w_en_rise) r_ncyc <= ncyc_decode(ncycle_jm);
      if (w_start) begin
        r_tick <= '0;
      end else if (w_run && fref_tick) begin
        r_tick <= w_tick_inc;
      end
      if (w_last) begin
        r_jm_out   <= w_ones_cnt;
        r_jm_nsamp <= w_samp_cnt;
        r_jm_sat   <= w_ones_sat || w_samp_sat;
      end
      r_busy <= (w_state_nxt == ARM) || (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign jm_out   = r_jm_out;
  assign jm_nsamp = r_jm_nsamp;
  assign jm_sat   = r_jm_sat;
  assign jm_busy  = r_busy;
  assign jm_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mdll_jm_counter.sv
// ============================================================================
// Module : tb_mdll_jm_counter
// Brief  : Directed self-checking bench for mdll_jm_counter (reduced ceiling).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mdll_jm_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_jm;
  logic [5:0]  ncycle_jm;
  logic        fref_tick;
  logic        pd_bit;
  logic [19:0] jm_out;
  logic [19:0] jm_nsamp;
  logic        jm_busy;
  logic        jm_done;
  logic        jm_sat;

  int n_checks = 0;
  int n_errors = 0;

  // Ceiling lowered to 1023 so saturation is reachable in a short run.
  mdll_jm_counter #(
    .SAT_MAX (20'h003FF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_jm     (en_jm),
    .ncycle_jm (ncycle_jm),
    .fref_tick (fref_tick),
    .pd_bit    (pd_bit),
    .jm_out    (jm_out),
    .jm_nsamp  (jm_nsamp),
    .jm_busy   (jm_busy),
    .jm_done   (jm_done),
    .jm_sat    (jm_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: pd_bit=0, 1: pd_bit=1, 2: pd_bit toggles every cycle
  task automatic tick_train(input int period, input int nticks, input int mode);
    for (int k = 0; k < nticks; k++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        fref_tick = (c == period - 1);
        case (mode)
          0:       pd_bit = 1'b0;
          1:       pd_bit = 1'b1;
          default: pd_bit = ~pd_bit;
        endcase
      end
    end
    @(negedge clk);
    fref_tick = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    en_jm     = 1'b0;
    ncycle_jm = 6'd0;
    fref_tick = 1'b0;
    pd_bit    = 1'b0;
    cycles(3);
    check("rst_out",   32'(jm_out),   32'd0);
    check("rst_nsamp", 32'(jm_nsamp), 32'd0);
    check("rst_busy",  32'(jm_busy),  32'd0);
    check("rst_done",  32'(jm_done),  32'd0);
    check("rst_sat",   32'(jm_sat),   32'd0);
    reset = 1'b0;
    cycles(1);

    // N=2, period 10, pd=1 -> 20 samples, all ones
    ncycle_jm = 6'd2;
    en_jm     = 1'b1;
    cycles(1);
    check("a_arm_busy", 32'(jm_busy), 32'd1);
    tick_train(10, 3, 1);
    check("a_out",   32'(jm_out),   32'd20);
    check("a_nsamp", 32'(jm_nsamp), 32'd20);
    check("a_sat",   32'(jm_sat),   32'd0);
    check("a_done",  32'(jm_done),  32'd1);
    check("a_busy",  32'(jm_busy),  32'd0);

    // en held high in DONE: further ticks must not restart
    tick_train(10, 3, 1);
    check("hold_done", 32'(jm_done), 32'd1);
    check("hold_busy", 32'(jm_busy), 32'd0);
    check("hold_out",  32'(jm_out),  32'd20);
    en_jm = 1'b0;
    cycles(1);
    check("drop_done", 32'(jm_done), 32'd0);

    // N=3 aborted after one counted tick: previous results survive
    ncycle_jm = 6'd3;
    en_jm     = 1'b1;
    cycles(1);
    check("ab_arm_busy", 32'(jm_busy), 32'd1);
    check("ab_arm_out",  32'(jm_out),  32'd20);
    tick_train(10, 2, 1);
    check("ab_run_busy", 32'(jm_busy), 32'd1);
    check("ab_run_done", 32'(jm_done), 32'd0);
    en_jm = 1'b0;
    cycles(1);
    check("ab_busy",  32'(jm_busy),  32'd0);
    check("ab_done",  32'(jm_done),  32'd0);
    check("ab_out",   32'(jm_out),   32'd20);
    check("ab_nsamp", 32'(jm_nsamp), 32'd20);

    // N=4, period 8, alternating pd -> 32 samples, 16 ones
    ncycle_jm = 6'd4;
    en_jm     = 1'b1;
    tick_train(8, 5, 2);
    check("b_out",   32'(jm_out),   32'd16);
    check("b_nsamp", 32'(jm_nsamp), 32'd32);
    check("b_sat",   32'(jm_sat),   32'd0);
    check("b_done",  32'(jm_done),  32'd1);
    en_jm = 1'b0;
    cycles(1);

    // ncycle 0 -> 64 periods of 20 = 1280 samples, beyond the 1023 ceiling
    ncycle_jm = 6'd0;
    en_jm     = 1'b1;
    tick_train(20, 65, 1);
    check("s1_out",   32'(jm_out),   32'h3FF);
    check("s1_nsamp", 32'(jm_nsamp), 32'h3FF);
    check("s1_sat",   32'(jm_sat),   32'd1);
    check("s1_done",  32'(jm_done),  32'd1);
    en_jm = 1'b0;
    cycles(1);

    // Only the sample counter saturates; ones stays 0
    en_jm = 1'b1;
    tick_train(20, 65, 0);
    check("s2_out",   32'(jm_out),   32'd0);
    check("s2_nsamp", 32'(jm_nsamp), 32'h3FF);
    check("s2_sat",   32'(jm_sat),   32'd1);
    en_jm = 1'b0;
    cycles(1);

    // Reset mid-RUN, then en_jm still high must not start a window
    ncycle_jm = 6'd2;
    en_jm     = 1'b1;
    tick_train(10, 2, 1);
    check("r_pre_busy", 32'(jm_busy), 32'd1);
    reset = 1'b1;
    cycles(1);
    check("r_out",   32'(jm_out),   32'd0);
    check("r_nsamp", 32'(jm_nsamp), 32'd0);
    check("r_sat",   32'(jm_sat),   32'd0);
    check("r_busy",  32'(jm_busy),  32'd0);
    check("r_done",  32'(jm_done),  32'd0);
    reset = 1'b0;
    tick_train(10, 3, 1);
    check("r_nostart_busy", 32'(jm_busy), 32'd0);
    check("r_nostart_done", 32'(jm_done), 32'd0);
    check("r_nostart_out",  32'(jm_out),  32'd0);
    en_jm = 1'b0;
    cycles(1);
    en_jm = 1'b1;
    cycles(1);
    check("r_restart_busy", 32'(jm_busy), 32'd1);
    tick_train(10, 3, 1);
    check("r_new_out",   32'(jm_out),   32'd20);
    check("r_new_nsamp", 32'(jm_nsamp), 32'd20);
    check("r_new_done",  32'(jm_done),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
